// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - N-channel registered mux with round-robin / fixed-priority arbitration
module rr_mux_reg #(
    parameter int N  = 8,
    parameter int W  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    input  logic            prio_mode,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_sel,
    input  logic            out_ready
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SW-1:0]   out_sel_q,   out_sel_d;
    logic [SW-1:0]   ptr_q,       ptr_d;

    logic            load_en;
    logic            gnt_found;
    logic [SW-1:0]   gnt_idx;
    logic [N-1:0]    grant;

    // Channel at distance off from base, wrapping at N (N need not be a power of 2).
    function automatic logic [SW-1:0] rr_index(input logic [SW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return s[SW-1:0];
    endfunction

    assign load_en = !out_valid_q || out_ready;

    // Scan from the far end so the nearest requester is the last one written.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        if (prio_mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = i[SW-1:0];
                end
            end
        end else begin
            for (int off = N - 1; off >= 0; off--) begin
                if (in_valid[rr_index(ptr_q, off)]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = rr_index(ptr_q, off);
                end
            end
        end
    end

    always_comb begin
        grant    = gnt_found ? (N'(1) << gnt_idx) : '0;
        in_ready = (load_en && !reset) ? grant : '0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = gnt_found;
            if (gnt_found) begin
                out_data_d = in_data[int'(gnt_idx) * W +: W];
                out_sel_d  = gnt_idx;
                if (!prio_mode)
                    ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb/tb_rr_mux_reg.sv - scoreboard bench for rr_mux_reg at N=8/W=4 and N=5/W=8
module tb_rr_mux_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ready;
    logic        prio_mode;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_ready;

    logic [4:0]  in_valid5;
    logic [39:0] in_data5;
    logic [4:0]  in_ready5;
    logic        out_valid5;
    logic [7:0]  out_data5;
    logic [2:0]  out_sel5;
    logic        out_ready5;

    int n_chk  = 0;
    int n_fail = 0;
    int q8[$];
    int q5[$];

    always #5 clk = ~clk;

    rr_mux_reg #(.N(8), .W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .prio_mode(prio_mode), .out_valid(out_valid),
        .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
    );

    rr_mux_reg #(.N(5), .W(8)) dut5 (
        .clk(clk), .reset(reset), .in_valid(in_valid5), .in_data(in_data5),
        .in_ready(in_ready5), .prio_mode(1'b0), .out_valid(out_valid5),
        .out_data(out_data5), .out_sel(out_sel5), .out_ready(out_ready5)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon8
        int e;
        if (!reset && out_valid && out_ready) begin
            if (q8.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL mon8_extra: got sel=%0d data=%0h, required no beat", out_sel, out_data);
            end else begin
                e = q8.pop_front();
                chk("mon8_sel", int'(out_sel), e / 256);
                chk("mon8_data", int'(out_data), e % 256);
            end
        end
    end

    always @(negedge clk) begin : mon5
        int e;
        if (!reset && out_valid5 && out_ready5) begin
            if (q5.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL mon5_extra: got sel=%0d data=%0h, required no beat", out_sel5, out_data5);
            end else begin
                e = q5.pop_front();
                chk("mon5_sel", int'(out_sel5), e / 256);
                chk("mon5_data", int'(out_data5), e % 256);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        prio_mode  = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 8'hFF;
        out_ready5 = 1'b1;
        in_valid5  = '0;
        for (int i = 0; i < 8; i++) in_data[i*4 +: 4] = 4'(i);
        for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'(8'h10 + i);

        // Reset state, in_ready forced low while reset is high
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sel", int'(out_sel), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        step();
        reset = 1'b0;

        // Round-robin, all channels valid: 0..7,0
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rr_in_ready", int'(in_ready), 1 << (k % 8));
            q8.push_back((k % 8) * 256 + (k % 8));
            step();
        end
        in_valid = 8'h00;
        @(negedge clk);
        chk("idle_last_beat", int'(out_valid), 1);
        step();
        @(negedge clk);
        chk("idle_out_valid", int'(out_valid), 0);
        step();

        // Fixed priority, all channels valid
        prio_mode = 1'b1;
        in_valid  = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("fp_in_ready", int'(in_ready), 8'h01);
            q8.push_back(0);
            step();
        end
        in_valid  = 8'h00;
        prio_mode = 1'b0;
        step();
        step();

        // Pointer to 3 via a ch2 grant, then 7,2,7 across the wrap
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 8'h04;
        @(negedge clk);
        chk("wrap_setup", int'(in_ready), 8'h04);
        q8.push_back(2 * 256 + 2);
        step();
        in_valid = 8'h84;
        @(negedge clk);
        chk("wrap_g7a", int'(in_ready), 8'h80);
        q8.push_back(7 * 256 + 7);
        step();
        @(negedge clk);
        chk("wrap_g2", int'(in_ready), 8'h04);
        q8.push_back(2 * 256 + 2);
        step();
        @(negedge clk);
        chk("wrap_g7b", int'(in_ready), 8'h80);
        q8.push_back(7 * 256 + 7);
        step();
        in_valid = 8'h00;
        step();
        step();

        // Backpressure: ch5 data A held for 4 cycles, then ch1 follows without a bubble
        in_data[5*4 +: 4] = 4'hA;
        in_valid = 8'h20;
        @(negedge clk);
        chk("bp_load", int'(in_ready), 8'h20);
        q8.push_back(5 * 256 + 8'hA);
        step();
        in_valid  = 8'h02;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'(out_data), 4'hA);
            chk("bp_sel", int'(out_sel), 5);
            chk("bp_in_ready", int'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", int'(in_ready), 8'h02);
        q8.push_back(1 * 256 + 1);
        step();
        in_valid = 8'h00;
        @(negedge clk);
        chk("bp_nobubble_valid", int'(out_valid), 1);
        chk("bp_nobubble_sel", int'(out_sel), 1);
        step();
        step();

        // Mid-stream reset drops a held beat; round-robin restarts at ch0
        in_valid = 8'h08;
        @(negedge clk);
        chk("mr_load", int'(in_ready), 8'h08);
        step();
        in_valid  = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        chk("mr_held_valid", int'(out_valid), 1);
        chk("mr_held_sel", int'(out_sel), 3);
        step();
        reset     = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mr_in_ready_rst", int'(in_ready), 0);
        step();
        @(negedge clk);
        chk("mr_out_valid", int'(out_valid), 0);
        chk("mr_out_sel", int'(out_sel), 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mr_restart", int'(in_ready), 8'h01);
        q8.push_back(0);
        step();
        in_valid = 8'h00;
        step();
        step();

        // N=5, W=8: 0..4,0
        in_valid5 = 5'h1F;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("n5_in_ready", int'(in_ready5), 1 << (k % 5));
            q5.push_back((k % 5) * 256 + 8'h10 + (k % 5));
            step();
        end
        in_valid5 = '0;
        step();
        step();

        chk("q8_drained", q8.size(), 0);
        chk("q5_drained", q5.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
